// File: rtl/data_mem_bridge.sv
// data_mem_bridge: load/store stage placed after a single-cycle datapath.
// Accesses at or above IO_BASE hit a small register block (LEDs, switches,
// status) in one cycle without stalling. Accesses below IO_BASE run a req/ack
// transaction to external RAM, and the core is stalled while it is outstanding.
//
// Ports
//   CLK, reset          clock and asynchronous active-low reset
//   MemWrite, MemRead   access request from the control unit (both set = write)
//   Addr, WriteData     byte address (ALUResult) and store data (RD2)
//   ReadData            load data for the writeback mux
//   Stall               hold PC / suppress RegWrite
//   mem_req/we/addr/wdata, mem_rdata, mem_ack   external RAM handshake
//   leds, switches      LED register output, raw switch input
//   bus_err             sticky timeout flag
module data_mem_bridge #(
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000,
  parameter int unsigned LED_W       = 8,
  parameter int unsigned SW_W        = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic             Stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [LED_W-1:0] leds,
  input  logic [SW_W-1:0]  switches,
  output logic             bus_err
);

  localparam int unsigned       TimerW     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TimerW-1:0] TimerLast  = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [31:0]       BusErrData = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q;
  logic [31:0]       rdata_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [LED_W-1:0]  leds_q;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  logic              bus_err_q;

  logic        access, is_wr, is_rd, io;
  logic [29:0] io_word;
  logic [31:0] io_rdata;
  logic        io_acc_en, io_rd_en, led_we, stat_clr;
  logic        stall_raw, ext_start, take_ack, time_out;

  // Byte lanes are not supported; the low address bits are intentionally dropped.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^Addr[1:0];

  assign access  = MemRead | MemWrite;
  assign is_wr   = MemWrite;
  assign is_rd   = MemRead & ~MemWrite;
  assign io      = (Addr >= IO_BASE);
  assign io_word = Addr[31:2] - IO_BASE[31:2];

  // I/O is only serviced from IDLE; REQ/DONE ignore the datapath inputs.
  assign io_acc_en = (state_q == StIdle) & access & io;
  assign io_rd_en  = io_acc_en & is_rd;
  assign led_we    = io_acc_en & is_wr & (io_word == 30'd0);
  assign stat_clr  = io_acc_en & is_wr & (io_word == 30'd2) & WriteData[0];

  always_comb begin
    io_rdata = '0;
    case (io_word)
      30'd0:   io_rdata = 32'(leds_q);
      30'd1:   io_rdata = 32'(sw_sync_q);
      30'd2:   io_rdata = {31'b0, bus_err_q};
      default: io_rdata = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    ext_start = 1'b0;
    take_ack  = 1'b0;
    time_out  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access && !io) begin
          stall_raw = 1'b1;
          ext_start = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        stall_raw = 1'b1;
        // An ack in the last allowed cycle still counts as a real completion.
        if (mem_ack) begin
          take_ack = 1'b1;
          state_d  = StDone;
        end else if (timer_q == TimerLast) begin
          time_out = 1'b1;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (ext_start) begin
        timer_q <= '0;
      end else if (state_q == StReq) begin
        timer_q <= timer_q + TimerW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (ext_start) begin
      addr_q  <= {Addr[31:2], 2'b00};
      wdata_q <= WriteData;
      we_q    <= is_wr;
    end
  end

  // Holds the last load result so ReadData stays stable through DONE and idle cycles.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (take_ack) begin
      rdata_q <= mem_rdata;
    end else if (time_out) begin
      rdata_q <= BusErrData;
    end else if (io_rd_en) begin
      rdata_q <= io_rdata;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      if (led_we) begin
        leds_q <= WriteData[LED_W-1:0];
      end
      // Timeout set takes priority over a W1C clear.
      if (time_out) begin
        bus_err_q <= 1'b1;
      end else if (stat_clr) begin
        bus_err_q <= 1'b0;
      end
    end
  end

  // Stall is forced low while reset is held so the core is never frozen by a stale request.
  assign Stall     = stall_raw & reset;
  assign mem_req   = (state_q == StReq);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ReadData  = io_rd_en ? io_rdata : rdata_q;
  assign leds      = leds_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed testbench for data_mem_bridge. Inputs change 1 time unit after the
// rising edge; outputs are sampled 4 units after the edge (mid-cycle).
module tb_data_mem_bridge;

  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

  logic        CLK;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [7:0]  leds;
  logic [7:0]  switches;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  data_mem_bridge #(
    .IO_BASE     (IO_BASE),
    .LED_W       (8),
    .SW_W        (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .leds      (leds),
    .switches  (switches),
    .bus_err   (bus_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; Addr = '0; WriteData = '0;
    mem_rdata = '0; mem_ack = 1'b0; switches = '0;
    settle();
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want %h", ReadData, 32'h0); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_req); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", Stall); end
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL rst_leds: got %h want 00", leds); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_buserr: got %b want 0", bus_err); end
    checks++; if (mem_addr !== 32'h0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_mem: got addr %h we %b want 0/0", mem_addr, mem_we);
    end
    tick(); tick();
    reset = 1'b1;
    settle();
  endtask

  task automatic test_load();
    int stall_cnt = 0;
    tick();
    MemRead = 1'b1; Addr = 32'h0000_0100;
    settle();
    if (Stall === 1'b1) stall_cnt++;
    checks++; if (Stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL load_idle: got stall %b req %b want 1/0", Stall, mem_req);
    end
    tick();
    MemRead = 1'b0; Addr = 32'h0000_0F00;  // must be ignored while in REQ
    settle();
    if (Stall === 1'b1) stall_cnt++;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0100 || mem_we !== 1'b0) begin
      errors++; $display("FAIL load_req: got req %b addr %h we %b want 1/00000100/0", mem_req, mem_addr, mem_we);
    end
    tick(); settle();
    if (Stall === 1'b1) stall_cnt++;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    settle();
    if (Stall === 1'b1) stall_cnt++;
    checks++; if (mem_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL load_addr_hold: got %h want 00000100", mem_addr);
    end
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    settle();
    if (Stall === 1'b1) stall_cnt++;
    checks++; if (ReadData !== 32'h1234_5678 || Stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL load_done: got rd %h stall %b req %b want 12345678/0/0", ReadData, Stall, mem_req);
    end
    checks++; if (stall_cnt != 4) begin errors++; $display("FAIL load_stall_cycles: got %0d want 4", stall_cnt); end
    tick(); settle();
    checks++; if (ReadData !== 32'h1234_5678) begin
      errors++; $display("FAIL load_idle_hold: got %h want 12345678", ReadData);
    end
  endtask

  task automatic test_store();
    int stall_cnt = 0;
    tick();
    MemWrite = 1'b1; Addr = 32'h0000_0203; WriteData = 32'hA5A5_0001;
    settle();
    if (Stall === 1'b1) stall_cnt++;
    tick();
    MemWrite = 1'b0; mem_ack = 1'b1;
    settle();
    if (Stall === 1'b1) stall_cnt++;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0000_0200 || mem_wdata !== 32'hA5A5_0001 || mem_req !== 1'b1) begin
      errors++; $display("FAIL store_req: got we %b addr %h wdata %h req %b want 1/00000200/a5a50001/1",
                         mem_we, mem_addr, mem_wdata, mem_req);
    end
    tick();
    mem_ack = 1'b0;
    settle();
    if (Stall === 1'b1) stall_cnt++;
    checks++; if (Stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL store_done: got stall %b req %b want 0/0", Stall, mem_req);
    end
    checks++; if (stall_cnt != 2) begin errors++; $display("FAIL store_stall_cycles: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    tick();
    MemRead = 1'b1; Addr = 32'h0000_0400;
    settle();
    tick();
    MemRead = 1'b0;
    for (int i = 0; i < 16; i++) begin
      settle();
      if (mem_req === 1'b1) req_cnt++;
      tick();
    end
    settle();
    checks++; if (req_cnt != 16) begin errors++; $display("FAIL to_req_cycles: got %0d want 16", req_cnt); end
    checks++; if (ReadData !== 32'hDEAD_BEEF || bus_err !== 1'b1 || Stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL to_done: got rd %h err %b stall %b req %b want deadbeef/1/0/0",
                         ReadData, bus_err, Stall, mem_req);
    end
    tick();
    MemRead = 1'b1; Addr = IO_BASE + 32'd8;
    settle();
    checks++; if (ReadData !== 32'h0000_0001 || Stall !== 1'b0) begin
      errors++; $display("FAIL to_stat_rd: got rd %h stall %b want 00000001/0", ReadData, Stall);
    end
    MemRead = 1'b0; MemWrite = 1'b1; WriteData = 32'h0;
    tick(); settle();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_w0_keep: got %b want 1", bus_err); end
    WriteData = 32'h1;
    tick();
    MemWrite = 1'b0;
    settle();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_w1c: got %b want 0", bus_err); end
  endtask

  task automatic test_io();
    tick();
    MemWrite = 1'b1; Addr = IO_BASE; WriteData = 32'h0000_003C;
    settle();
    checks++; if (Stall !== 1'b0 || leds !== 8'h00) begin
      errors++; $display("FAIL io_led_pre: got stall %b leds %h want 0/00", Stall, leds);
    end
    tick();
    MemWrite = 1'b0;
    settle();
    checks++; if (leds !== 8'h3C) begin errors++; $display("FAIL io_led: got %h want 3c", leds); end
    MemRead = 1'b1; Addr = IO_BASE;
    settle();
    checks++; if (ReadData !== 32'h0000_003C || Stall !== 1'b0) begin
      errors++; $display("FAIL io_led_rd: got rd %h stall %b want 0000003c/0", ReadData, Stall);
    end
    Addr = IO_BASE + 32'd4;
    switches = 8'h81;
    tick(); settle();
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL io_sw_1clk: got %h want 00000000", ReadData); end
    tick(); settle();
    checks++; if (ReadData !== 32'h0000_0081) begin errors++; $display("FAIL io_sw_2clk: got %h want 00000081", ReadData); end
    Addr = IO_BASE + 32'd12;
    settle();
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL io_unmapped: got %h want 00000000", ReadData); end
    MemRead = 1'b0;
  endtask

  task automatic test_ack_at_timeout();
    tick();
    MemRead = 1'b1; Addr = 32'h0000_0800;
    settle();
    tick();
    MemRead = 1'b0;
    for (int i = 0; i < 15; i++) begin
      settle();
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    settle();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ackto_last_req: got %b want 1", mem_req); end
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    settle();
    checks++; if (ReadData !== 32'hCAFE_F00D || bus_err !== 1'b0 || Stall !== 1'b0) begin
      errors++; $display("FAIL ackto_done: got rd %h err %b stall %b want cafef00d/0/0", ReadData, bus_err, Stall);
    end
  endtask

  task automatic test_async_reset();
    tick();
    MemWrite = 1'b1; Addr = IO_BASE; WriteData = 32'h0000_00FF;
    tick();
    MemWrite = 1'b0; MemRead = 1'b1; Addr = 32'h0000_0500;
    tick();
    MemRead = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    // DONE after timeout; go back to IDLE and start another load
    tick();
    MemRead = 1'b1; Addr = 32'h0000_0600;
    tick();
    tick();
    settle();
    checks++; if (mem_req !== 1'b1 || leds !== 8'hFF || bus_err !== 1'b1) begin
      errors++; $display("FAIL arst_pre: got req %b leds %h err %b want 1/ff/1", mem_req, leds, bus_err);
    end
    reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || Stall !== 1'b0 || leds !== 8'h00 || bus_err !== 1'b0 || ReadData !== 32'h0) begin
      errors++; $display("FAIL arst_now: got req %b stall %b leds %h err %b rd %h want 0/0/00/0/00000000",
                         mem_req, Stall, leds, bus_err, ReadData);
    end
    MemRead = 1'b0;
    tick();
    reset = 1'b1;
    tick(); settle();
    checks++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin
      errors++; $display("FAIL arst_idle: got req %b stall %b want 0/0", mem_req, Stall);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_io();
    test_ack_at_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
